wind_light_sched: RTL and testbench
===================================

WIND_LIGHT_SCHED -- requirements
Module: wind_light_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4, meaning clk cycles per pattern step (legal range 2..65535).
REQ-002 SHALL have parameter CW, default 16, meaning tick counter width (2^CW >= TICK_DIV).
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sw  input  2  manual mode from the panel switches, asynchronous to clk.
REQ-006 SHALL have port hold  input  1  freezes stepping while high.
REQ-007 SHALL have port rem_req  input  1  remote override request, level, held high for the duration of the override.
REQ-008 SHALL have port rem_mode  input  2  remote mode, sampled at grant.
REQ-009 SHALL have port rem_gnt  output  1  remote override granted.
REQ-010 SHALL have port lamps  output  3  lamp drive, bit 2 = left lamp, bit 0 = right lamp.
REQ-011 SHALL have port step  output  1  one-cycle pulse on every pattern step.
REQ-012 SHALL have port cur_mode  output  2  mode currently displayed.

Function
REQ-013 Mode encoding SHALL be: 00 CALM, 01 RIGHT, 10 LEFT, 11 OFF.
REQ-014 Pattern tables SHALL be, by phase: CALM 101,010 (period 2); RIGHT 001,010,100 (period 3); LEFT 100,010,001 (period 3); OFF 000 (period 1).
REQ-015 sw SHALL pass through a two-flop synchronizer before any use (sw_s); all other inputs are synchronous.
REQ-016 Tick counter cnt SHALL count 0..TICK_DIV-1 and wrap to 0 when hold is low; it SHALL hold its value while hold is high.
REQ-017 step SHALL be registered and SHALL be high for exactly the cycle after the edge at which cnt wraps (cnt==TICK_DIV-1 and hold low). The step-edge is that wrap edge.
REQ-018 Arbiter states SHALL be LOCAL and REMOTE; rem_gnt SHALL be 1 exactly in REMOTE.
REQ-019 LOCAL->REMOTE SHALL occur at the first edge with rem_req high; the same edge SHALL latch rem_mode into rem_lat.
REQ-020 REMOTE->LOCAL SHALL occur at the first edge with rem_req low; rem_mode changes during REMOTE SHALL be ignored.
REQ-021 Pending mode SHALL be rem_lat when rem_gnt is high, else sw_s, using register values before the edge.
REQ-022 At each step-edge: if pending != cur_mode, cur_mode SHALL take pending and phase SHALL go to 0; else phase SHALL advance by 1, wrapping at the mode period.
REQ-023 Mode and phase SHALL change only at step-edges; hold high SHALL freeze both cur_mode and phase.
REQ-024 lamps SHALL be a pure function of the cur_mode and phase registers, so it changes in the same cycle as step.
REQ-025 A rem_req rise coinciding with a step-edge SHALL NOT affect that step; the override SHALL take effect at the next step-edge.
REQ-026 A rem_req pulse of 1 cycle SHALL still produce a 1-cycle rem_gnt and no mode change unless a step-edge occurs while rem_gnt is high.

Reset
REQ-027 In the cycle after an edge with reset high: cnt=0, phase=0, cur_mode=CALM, lamps=101, step=0, rem_gnt=0, rem_lat=00, synchronizer flops=00.
REQ-028 Reset SHALL override hold, rem_req and an in-progress step; a held rem_req SHALL be granted at the first edge after reset deasserts.

Verification
REQ-029 Reset, sw=00, hold=0, TICK_DIV=4 -> step every 4th cycle; lamps 101,010,101,... alternating per step.
REQ-030 sw 00->01 mid-period -> after 2-cycle sync, next step-edge lamps=001, then 010,100,001 on following steps; cur_mode=01.
REQ-031 LEFT running, rem_req=1 rem_mode=11 -> rem_gnt=1 next cycle; next step lamps=000; rem_mode changed to 00 while granted -> still 000; rem_req=0 -> rem_gnt=0 next cycle, next step returns to LEFT phase 0 (100).
REQ-032 hold=1 for 10 cycles in RIGHT phase 1 -> no step, lamps stay 010, cnt frozen; hold=0 -> stepping resumes from the frozen cnt, next lamps 100.
REQ-033 rem_req rises on a step-edge -> that step follows local mode; override visible one step later.
REQ-034 reset asserted mid-RIGHT with rem_req=1 -> lamps=101, rem_gnt=0 after the edge; rem_gnt=1 one cycle after reset drops.

Source files
------------

// File: rtl/wind_light_sched.sv
// Wind-light pattern scheduler: steps a lamp pattern at a fixed tick rate,
// chooses between the panel switches and a remote override, and freezes on hold.
module wind_light_sched #(
  parameter int TICK_DIV = 4,
  parameter int CW       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw,
  input  logic       hold,
  input  logic       rem_req,
  input  logic [1:0] rem_mode,
  output logic       rem_gnt,
  output logic [2:0] lamps,
  output logic       step,
  output logic [1:0] cur_mode
);

  localparam logic [1:0] ModeCalm  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeOff   = 2'b11;

  localparam logic [CW-1:0] CntLast = CW'(TICK_DIV - 1);

  typedef enum logic {
    ARB_LOCAL,
    ARB_REMOTE
  } arbState_t;

  logic [1:0]    swMeta_q, swSync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q;
  logic          wrap;
  arbState_t     arb_q;
  logic [1:0]    remLat_q;
  logic [1:0]    curMode_q, curMode_d;
  logic [1:0]    phase_q, phase_d;
  logic [1:0]    phaseLast;
  logic [1:0]    pending;

  assign wrap = !hold && (cnt_q == CntLast);

  // Two-flop synchronizer for the panel switches, which are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      swMeta_q <= 2'b00;
      swSync_q <= 2'b00;
    end else begin
      swMeta_q <= sw;
      swSync_q <= swMeta_q;
    end
  end

  // Tick counter next state: free-running divider that freezes while hold is high.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  // Tick counter and the registered one-cycle step pulse that follows each wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= wrap;
    end
  end

  // Remote arbiter: grant on the first edge with a request and latch the mode only then.
  always_ff @(posedge clk) begin
    if (reset) begin
      arb_q    <= ARB_LOCAL;
      remLat_q <= 2'b00;
    end else begin
      case (arb_q)
        ARB_LOCAL: begin
          if (rem_req) begin
            arb_q    <= ARB_REMOTE;
            remLat_q <= rem_mode;
          end
        end
        ARB_REMOTE: begin
          if (!rem_req) begin
            arb_q <= ARB_LOCAL;
          end
        end
        default: arb_q <= ARB_LOCAL;
      endcase
    end
  end

  assign rem_gnt = (arb_q == ARB_REMOTE);
  assign pending = rem_gnt ? remLat_q : swSync_q;

  // Mode and phase next state: switch mode and restart its pattern, or advance the phase.
  always_comb begin
    curMode_d = curMode_q;
    phase_d   = phase_q;
    case (curMode_q)
      ModeCalm:  phaseLast = 2'd1;
      ModeRight: phaseLast = 2'd2;
      ModeLeft:  phaseLast = 2'd2;
      default:   phaseLast = 2'd0;
    endcase
    if (wrap) begin
      if (pending != curMode_q) begin
        curMode_d = pending;
        phase_d   = 2'd0;
      end else begin
        phase_d = (phase_q == phaseLast) ? 2'd0 : phase_q + 2'd1;
      end
    end
  end

  // Mode and phase registers, updated only at step edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      curMode_q <= ModeCalm;
      phase_q   <= 2'd0;
    end else begin
      curMode_q <= curMode_d;
      phase_q   <= phase_d;
    end
  end

  // Lamp pattern lookup from the current mode and phase.
  always_comb begin
    lamps = 3'b000;
    case (curMode_q)
      ModeCalm:  lamps = (phase_q == 2'd0) ? 3'b101 : 3'b010;
      ModeRight: begin
        case (phase_q)
          2'd0:    lamps = 3'b001;
          2'd1:    lamps = 3'b010;
          default: lamps = 3'b100;
        endcase
      end
      ModeLeft: begin
        case (phase_q)
          2'd0:    lamps = 3'b100;
          2'd1:    lamps = 3'b010;
          default: lamps = 3'b001;
        endcase
      end
      ModeOff:   lamps = 3'b000;
      default:   lamps = 3'b000;
    endcase
  end

  assign step     = step_q;
  assign cur_mode = curMode_q;

endmodule

// File: tb/tb_wind_light_sched.sv
// Directed self-checking bench for wind_light_sched with the default TICK_DIV of 4.
module tb_wind_light_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sw;
  logic       hold;
  logic       rem_req;
  logic [1:0] rem_mode;
  logic       rem_gnt;
  logic [2:0] lamps;
  logic       step;
  logic [1:0] cur_mode;

  int compared   = 0;
  int mismatched = 0;
  int cycles;
  int stepsSeen;

  wind_light_sched dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .hold     (hold),
    .rem_req  (rem_req),
    .rem_mode (rem_mode),
    .rem_gnt  (rem_gnt),
    .lamps    (lamps),
    .step     (step),
    .cur_mode (cur_mode)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] s, input logic h,
                               input logic rq, input logic [1:0] rm);
    reset    = r;
    sw       = s;
    hold     = h;
    rem_req  = rq;
    rem_mode = rm;
  endtask

  // Advance one clock and sample 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until step is seen; returns the number of edges taken, or 99 on timeout.
  task automatic waitStep(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    checkOutput("reset_lamps", lamps, 3'b101);
    checkOutput("reset_step", step, 0);
    checkOutput("reset_gnt", rem_gnt, 0);
    checkOutput("reset_mode", cur_mode, 0);
    reset = 1'b0;

    // CALM alternation, one step every 4 cycles.
    waitStep(cycles);
    checkOutput("calm_first_step_cycles", cycles, 4);
    checkOutput("calm_lamps_1", lamps, 3'b010);
    waitStep(cycles);
    checkOutput("calm_period", cycles, 4);
    checkOutput("calm_lamps_2", lamps, 3'b101);
    tick();
    checkOutput("step_one_cycle", step, 0);

    // Switch to RIGHT mid-period (cnt=1); sync delay still lands on this wrap.
    sw = 2'b01;
    waitStep(cycles);
    checkOutput("right_switch_cycles", cycles, 3);
    checkOutput("right_lamps_p0", lamps, 3'b001);
    checkOutput("right_mode", cur_mode, 1);
    waitStep(cycles);
    checkOutput("right_lamps_p1", lamps, 3'b010);
    waitStep(cycles);
    checkOutput("right_lamps_p2", lamps, 3'b100);
    waitStep(cycles);
    checkOutput("right_lamps_wrap", lamps, 3'b001);
    waitStep(cycles);
    checkOutput("right_lamps_p1b", lamps, 3'b010);

    // Hold for 10 cycles with cnt at 2; resume needs only 2 more edges.
    tick();
    tick();
    hold = 1'b1;
    stepsSeen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step) stepsSeen++;
    end
    checkOutput("hold_no_step", stepsSeen, 0);
    checkOutput("hold_lamps", lamps, 3'b010);
    hold = 1'b0;
    waitStep(cycles);
    checkOutput("hold_resume_cycles", cycles, 2);
    checkOutput("hold_resume_lamps", lamps, 3'b100);

    // Go to LEFT.
    sw = 2'b10;
    waitStep(cycles);
    checkOutput("left_cycles", cycles, 4);
    checkOutput("left_lamps", lamps, 3'b100);
    checkOutput("left_mode", cur_mode, 2);

    // Remote override to OFF; later rem_mode changes are ignored.
    rem_req  = 1'b1;
    rem_mode = 2'b11;
    tick();
    checkOutput("remote_gnt", rem_gnt, 1);
    rem_mode = 2'b00;
    waitStep(cycles);
    checkOutput("remote_step_cycles", cycles, 3);
    checkOutput("remote_lamps", lamps, 3'b000);
    checkOutput("remote_mode", cur_mode, 3);
    waitStep(cycles);
    checkOutput("remote_ignore_mode", lamps, 3'b000);
    rem_req = 1'b0;
    tick();
    checkOutput("remote_release_gnt", rem_gnt, 0);
    waitStep(cycles);
    checkOutput("remote_release_cycles", cycles, 3);
    checkOutput("left_back_lamps", lamps, 3'b100);
    checkOutput("left_back_mode", cur_mode, 2);

    // rem_req rising on the step edge: that step stays local (LEFT phase 1).
    tick();
    tick();
    tick();
    rem_req  = 1'b1;
    rem_mode = 2'b00;
    tick();
    checkOutput("coincide_step", step, 1);
    checkOutput("coincide_gnt", rem_gnt, 1);
    checkOutput("coincide_lamps", lamps, 3'b010);
    checkOutput("coincide_mode", cur_mode, 2);
    waitStep(cycles);
    checkOutput("coincide_next_mode", cur_mode, 0);
    checkOutput("coincide_next_lamps", lamps, 3'b101);

    // Back to local RIGHT, then reset mid-pattern with a held request.
    rem_req = 1'b0;
    sw      = 2'b01;
    waitStep(cycles);
    checkOutput("right_again_cycles", cycles, 4);
    checkOutput("right_again_lamps", lamps, 3'b001);
    tick();
    rem_req  = 1'b1;
    rem_mode = 2'b10;
    reset    = 1'b1;
    tick();
    checkOutput("midreset_lamps", lamps, 3'b101);
    checkOutput("midreset_gnt", rem_gnt, 0);
    checkOutput("midreset_mode", cur_mode, 0);
    checkOutput("midreset_step", step, 0);
    tick();
    checkOutput("midreset_gnt_held", rem_gnt, 0);
    reset = 1'b0;
    tick();
    checkOutput("postreset_gnt", rem_gnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
